// File: rtl/exam_vector_checker.sv
// Exhaustive vector generator and answer/user output comparator.
// Optional HOLD_ON_FAIL_EN: stop the run at the first mismatch.
module exam_vector_checker #(
  parameter int IN_W    = 2,
  parameter int OUT_W   = 1,
  parameter int LAT     = 0,
  parameter int NUM_VEC = 2**IN_W,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] exp_o,
  input  logic [OUT_W-1:0] usr_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_vld,
  output logic [IN_W-1:0]  first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN,
    DONE
  } state_e;

  localparam logic [IN_W-1:0] LAST_VEC =
    IN_W'(NUM_VEC - 1);
  localparam logic [3:0] LAST_DRN =
    4'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [CNT_W-1:0] ERR_MAX =
    {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic [3:0]       drn_q, drn_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [IN_W-1:0]  ffv_q, ffv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             clr;
  logic             drv_vld;
  logic             cmp_vld;
  logic [IN_W-1:0]  cmp_vec;
  logic             mis;

  assign clr = start &&
    (state_q == IDLE || state_q == DONE);
  assign drv_vld = (state_q == DRIVE);

  // Valid/vector delay line aligning each compare with its stimulus
  generate
    if (LAT == 0) begin : g_comb
      assign cmp_vld = drv_vld;
      assign cmp_vec = stim_q;
    end else begin : g_pipe
      logic [LAT-1:0]  vld_q;
      logic [IN_W-1:0] vec_q [LAT];

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          vld_q <= '0;
          for (int i = 0; i < LAT; i++)
            vec_q[i] <= '0;
        end else begin
          vld_q[0] <= drv_vld;
          vec_q[0] <= stim_q;
          for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            vec_q[i] <= vec_q[i-1];
          end
        end
      end

      assign cmp_vld = vld_q[LAT-1];
      assign cmp_vec = vec_q[LAT-1];
    end
  endgenerate

  assign mis = cmp_vld &&
    (state_q == DRIVE || state_q == DRAIN) &&
    (exp_o != usr_o);

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    drn_d   = drn_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = DRIVE;
          stim_d  = '0;
        end
      end
      DRIVE: begin
        if (stim_q == LAST_VEC) begin
          state_d = (LAT > 0) ? DRAIN : DONE;
          drn_d   = '0;
        end else begin
          stim_d = stim_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == LAST_DRN)
          state_d = DONE;
        else
          drn_d = drn_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
`ifdef HOLD_ON_FAIL_EN
    if (mis) begin
      state_d = DONE;
      stim_d  = stim_q;
    end
`endif
  end

  always_comb begin
    err_d = err_q;
    fv_d  = fv_q;
    ffv_d = ffv_q;
    if (clr) begin
      err_d = '0;
      fv_d  = 1'b0;
      ffv_d = '0;
    end else if (mis) begin
      if (err_q != ERR_MAX)
        err_d = err_q + 1'b1;
      if (!fv_q) begin
        fv_d  = 1'b1;
        ffv_d = cmp_vec;
      end
    end
  end

  always_comb begin
    busy_d = (state_d == DRIVE) ||
             (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stim_q  <= '0;
      drn_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      drn_q   <= drn_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffv_q   <= ffv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign fail_vld       = fv_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: doc/exam_vector_checker.md
Name: exam_vector_checker

Overview:
- Synthesizable on-board counterpart to the simulation exam checker.
- Generates exhaustive input vectors for an exam problem and drives the same vector into both the reference `answer` model and the `user_answer` model.
- Compares their outputs cycle by cycle after a fixed latency, counts mismatches and records the first failing vector.
- Sits between the two answer instances at exam top level and reports pass/fail to a status block (LEDs/UART).

Parameters:
- IN_W, 2, width of stimulus vector driven to both models
- OUT_W, 1, width of each model's output
- LAT, 0, model response latency in clk cycles (0 = combinational models, max 15)
- NUM_VEC, 2**IN_W, number of vectors applied per run (1..2**IN_W)
- CNT_W, 16, width of mismatch counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run when idle or done
- stim  out  IN_W  vector driven to both models
- exp_o  in  OUT_W  reference model output
- usr_o  in  OUT_W  user model output
- busy  out  1  run in progress
- done  out  1  run complete; held until next start or rst
- pass  out  1  valid when done; 1 if no mismatch
- err_cnt  out  CNT_W  mismatch count, saturating
- fail_vld  out  1  first_fail_vec holds a captured vector
- first_fail_vec  out  IN_W  stimulus of the first mismatching compare

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset, sampled on a clk edge: state=IDLE, stim=0, busy=0, done=0, pass=0, err_cnt=0, fail_vld=0, first_fail_vec=0, delay pipeline cleared. Reset mid-run aborts the run; no partial result is retained.
- States and transitions:
  - IDLE: start -> DRIVE, clearing err_cnt, fail_vld, first_fail_vec and done.
  - DRIVE: one vector per cycle, stim = 0,1,...,NUM_VEC-1. After the cycle driving NUM_VEC-1: -> DRAIN if LAT>0, else -> DONE.
  - DRAIN: exactly LAT cycles, then -> DONE. stim holds its last value.
  - DONE: done=1, pass=(err_cnt==0). start -> DRIVE with the same clears as IDLE.
- busy=1 in DRIVE and DRAIN. start is ignored while busy.
- Compare pipeline:
  - A valid bit plus the stim value are delayed LAT stages. LAT=0 means a same-cycle compare.
  - A compare occurs when the delayed valid is 1; mismatch = (exp_o != usr_o), any bit.
- On mismatch:
  - err_cnt increments, saturating at 2**CNT_W-1 with no wrap.
  - If fail_vld=0: first_fail_vec <= delayed stim and fail_vld <= 1. Later mismatches do not overwrite it.
- Exactly NUM_VEC compares per run. No compare happens in IDLE/DONE, so model outputs there are don't-care.
- Latency: start at cycle 0 -> first stim in cycle 1 -> done=1 in cycle NUM_VEC+LAT+1.
- All outputs are registered except stim's combinational use by the models.

Optional Feature:
- HOLD_ON_FAIL_EN
- Defined:
  - On the first mismatch, go directly to DONE on the next edge, abandoning remaining vectors and any in-flight compares.
  - err_cnt=1, pass=0, fail_vld=1.
- Undefined: always run all NUM_VEC vectors as described above.

Test Plan:
- Both models 2-input AND, LAT=0. start at cycle 0 -> stim 0,1,2,3 in cycles 1..4; done=1 in cycle 5; pass=1, err_cnt=0, fail_vld=0.
- Reference AND, user OR, LAT=0 -> mismatches on vectors 1 and 2; done in cycle 5; err_cnt=2, pass=0, first_fail_vec=1, fail_vld=1.
- Both models registered AND, LAT=1 -> done in cycle 6, pass=1. With LAT=1 but a user model registered twice -> err_cnt nonzero, pass=0.
- start pulsed again in cycle 3 of a run -> ignored, sequence unchanged. rst asserted in cycle 3 -> all outputs 0 next cycle, and a new start runs cleanly from stim=0.
- After a failing run, start again with matching models -> counters cleared, pass=1, fail_vld=0.
- HOLD_ON_FAIL_EN defined, AND vs OR -> done in cycle 3 (mismatch seen at cycle 2, vector 1), err_cnt=1, first_fail_vec=1.
